// File: rtl/window_threshold_detector.sv
// window_threshold_detector
// Multi-channel sliding-window ones counter with a runtime threshold compare.
// Each channel keeps its last WINDOW accepted bits and a running ones count.
// The count is updated incrementally, never by popcount.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   clear      synchronous flush of all window state (wins over in_valid)
//   in_valid   qualifies in_data
//   in_data    one bit per channel
//   threshold  compare threshold, used on each accepted sample
//   mode       00 >=, 01 ==, 10 <=, 11 >
//   out_valid  one-cycle pulse after each accepted sample
//   hit        per-channel registered compare result
//   count      per-channel ones count, channel c at [c*CNT_W +: CNT_W]
//   primed     high once WINDOW samples accepted since reset/clear
module window_threshold_detector #(
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  WINDOW   = 8,
    localparam int unsigned CNT_W    = $clog2(WINDOW + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       in_data,
    input  logic [CNT_W-1:0]          threshold,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic                      primed
);

    logic [WINDOW-1:0]   shift_q [CHANNELS];
    logic [WINDOW-1:0]   shift_d [CHANNELS];
    logic [CNT_W-1:0]    count_q [CHANNELS];
    logic [CNT_W-1:0]    count_d [CHANNELS];
    logic [CNT_W-1:0]    fill_q;
    logic [CNT_W-1:0]    fill_d;
    logic [CHANNELS-1:0] hit_q;
    logic [CHANNELS-1:0] hit_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                primed_q;
    logic                primed_d;

    // Threshold compare; an out-of-range threshold naturally yields 0 for
    // >=, ==, > and 1 for <=.
    function automatic logic compare_hit(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] thr,
                                         input logic [1:0]       md);
        case (md)
            2'b00:   return cnt >= thr;
            2'b01:   return cnt == thr;
            2'b10:   return cnt <= thr;
            default: return cnt > thr;
        endcase
    endfunction

    // Next-state logic for windows, counts, fill and status.
    always_comb begin
        shift_d     = shift_q;
        count_d     = count_q;
        hit_d       = hit_q;
        fill_d      = fill_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;

        if (clear) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shift_d[c] = '0;
                count_d[c] = '0;
            end
            hit_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (in_valid) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shift_d[c] = {shift_q[c][WINDOW-2:0], in_data[c]};
                // Increment and decrement are exclusive, so the count never
                // leaves 0..WINDOW: a set outgoing bit implies count >= 1,
                // and a clear one implies count <= WINDOW-1.
                if (in_data[c] && !shift_q[c][WINDOW-1]) begin
                    count_d[c] = count_q[c] + CNT_W'(1);
                end else if (!in_data[c] && shift_q[c][WINDOW-1]) begin
                    count_d[c] = count_q[c] - CNT_W'(1);
                end
                hit_d[c] = compare_hit(count_d[c], threshold, mode);
            end
            if (fill_q != CNT_W'(WINDOW)) begin
                fill_d = fill_q + CNT_W'(1);
            end
            primed_d    = (fill_d == CNT_W'(WINDOW));
            out_valid_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shift_q[c] <= '0;
                count_q[c] <= '0;
            end
            hit_q       <= '0;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shift_q[c] <= shift_d[c];
                count_q[c] <= count_d[c];
            end
            hit_q       <= hit_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Pack per-channel counts onto the output bus.
    always_comb begin
        count = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            count[c*CNT_W +: CNT_W] = count_q[c];
        end
    end

    assign hit       = hit_q;
    assign out_valid = out_valid_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_window_threshold_detector.sv
// Testbench for window_threshold_detector: a 1-channel/3-deep instance driven
// from a vector table, and a 4-channel/8-deep instance checked every cycle
// against a queue-based reference model plus directed corner sequences.
module tb_window_threshold_detector;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-channel, 8-deep instance
    logic          clear, in_valid;
    logic [CH-1:0] in_data;
    logic [CW-1:0] threshold;
    logic [1:0]    mode;
    logic          out_valid, primed;
    logic [CH-1:0] hit;
    logic [CH*CW-1:0] count;

    // 1-channel, 3-deep instance
    logic       a_clear, a_valid;
    logic [0:0] a_data;
    logic [1:0] a_th;
    logic [1:0] a_mode;
    logic       a_ov, a_primed;
    logic [0:0] a_hit;
    logic [1:0] a_count;

    window_threshold_detector #(.CHANNELS(CH), .WINDOW(W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .threshold(threshold), .mode(mode),
        .out_valid(out_valid), .hit(hit), .count(count), .primed(primed)
    );

    window_threshold_detector #(.CHANNELS(1), .WINDOW(3)) dut3 (
        .clk(clk), .reset(reset), .clear(a_clear), .in_valid(a_valid),
        .in_data(a_data), .threshold(a_th), .mode(a_mode),
        .out_valid(a_ov), .hit(a_hit), .count(a_count), .primed(a_primed)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted sample words, newest at the front.
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_hit;
    logic          m_ov;

    function automatic int unsigned ones(input int unsigned c);
        int unsigned n = 0;
        foreach (hist[i]) n += 32'(hist[i][c]);
        return n;
    endfunction

    function automatic logic ref_hit(input int unsigned n, input int unsigned th, input logic [1:0] md);
        case (md)
            2'b00:   return n >= th;
            2'b01:   return n == th;
            2'b10:   return n <= th;
            default: return n > th;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        m_hit = '0;
        m_ov  = 1'b0;
    endtask

    task automatic model_edge(input logic clr, input logic v, input logic [CH-1:0] d,
                              input logic [CW-1:0] th, input logic [1:0] md);
        if (clr) begin
            model_reset();
        end else if (v) begin
            hist.push_front(d);
            if (hist.size() > W) void'(hist.pop_back());
            for (int unsigned c = 0; c < CH; c++) m_hit[c] = ref_hit(ones(c), 32'(th), md);
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [CH*CW-1:0] e;
        e = '0;
        for (int unsigned c = 0; c < CH; c++) e[c*CW +: CW] = CW'(ones(c));
        chk("count", 32'(count), 32'(e));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("primed", 32'(primed), 32'(hist.size() == W));
    endtask

    // One clock of the 4-channel instance with model comparison after the edge.
    task automatic step(input logic clr, input logic v, input logic [CH-1:0] d,
                        input logic [CW-1:0] th, input logic [1:0] md);
        clear = clr; in_valid = v; in_data = d; threshold = th; mode = md;
        @(posedge clk);
        model_edge(clr, v, d, th, md);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic        din;
        logic        ehit;
        int unsigned ecnt;
        logic        eprimed;
    } vec_t;

    typedef struct {
        logic [CW-1:0] th;
        logic [1:0]    md;
        logic          ehit;
    } mvec_t;

    vec_t  tbl[7];
    mvec_t mtbl[6];
    logic [7:0] pat;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 2, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 2, 1'b1};
        mtbl[0] = '{4'd5, 2'b00, 1'b1};
        mtbl[1] = '{4'd5, 2'b01, 1'b1};
        mtbl[2] = '{4'd5, 2'b10, 1'b1};
        mtbl[3] = '{4'd5, 2'b11, 1'b0};
        mtbl[4] = '{4'd9, 2'b00, 1'b0};
        mtbl[5] = '{4'd9, 2'b10, 1'b1};
        pat = 8'b0001_1111;

        reset = 1'b1;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; threshold = '0; mode = '0;
        a_clear = 1'b0; a_valid = 1'b0; a_data = '0; a_th = 2'd2; a_mode = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_primed", 32'(primed), 32'd0);
        reset = 1'b0;

        // Default-equivalent 3-sample detector from a vector table.
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1;
            a_data  = tbl[i].din;
            @(posedge clk);
            #1;
            chk("w3_hit", 32'(a_hit), 32'(tbl[i].ehit));
            chk("w3_count", 32'(a_count), tbl[i].ecnt);
            chk("w3_primed", 32'(a_primed), 32'(tbl[i].eprimed));
            chk("w3_out_valid", 32'(a_ov), 32'd1);
        end
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w3_idle_out_valid", 32'(a_ov), 32'd0);
        chk("w3_idle_count_hold", 32'(a_count), 32'd2);
        chk("w3_idle_hit_hold", 32'(a_hit), 32'd1);

        // Gapped valid, channel 0 all ones.
        for (int i = 0; i < 18; i++) begin
            step(1'b0, (i % 2) == 0, 4'b0001, 4'd8, 2'b00);
            if (i == 7) chk("gap_not_primed_at_cycle8", 32'(primed), 32'd0);
        end
        chk("gap_count_sat", 32'(count[CW-1:0]), 32'd8);
        chk("gap_primed", 32'(primed), 32'd1);
        chk("gap_hit", 32'(hit[0]), 32'd1);

        // Modes at count=5 using a period-8 pattern so the count stays constant.
        step(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, {3'b000, pat[i]}, 4'd5, 2'b00);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, {3'b000, pat[k]}, mtbl[k].th, mtbl[k].md);
            chk("mode_count5", 32'(count[CW-1:0]), 32'd5);
            chk("mode_hit", 32'(hit[0]), 32'(mtbl[k].ehit));
        end

        // Clear has priority over a simultaneous valid sample.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b1111, 4'd8, 2'b00);
        step(1'b1, 1'b1, 4'b1111, 4'd8, 2'b00);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_hit", 32'(hit), 32'd0);
        chk("clear_primed", 32'(primed), 32'd0);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 4'b0001, 4'd8, 2'b00);
        chk("clear_then_one", 32'(count[CW-1:0]), 32'd1);

        // Asynchronous reset between edges with count=6.
        step(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0001, 4'd3, 2'b00);
        chk("pre_reset_count6", 32'(count[CW-1:0]), 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_hit", 32'(hit), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_primed", 32'(primed), 32'd0);
        model_reset();
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 4'b0001, 4'd3, 2'b00);
        chk("post_reset_first", 32'(count[CW-1:0]), 32'd1);

        // Multi-channel independence.
        step(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b0101, 4'd8, 2'b00);
        chk("multi_hit", 32'(hit), 32'h5);
        chk("multi_count", 32'(count), 32'h0808);

        // Randomized streams against the reference model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 CH'($urandom), CW'($urandom_range(0, 15)), 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_threshold_detector.md
# window_threshold_detector

Multi-channel, parametrised sliding-window threshold detector. Each channel tracks how many '1's occurred in its last WINDOW accepted samples and compares that count against a runtime threshold under a selectable comparison mode. It generalises the fixed 3-sample, "more than one '1'" detector. It sits after input synchronisation, alongside the team's other serial-pattern FSM blocks.

## Interface
- CHANNELS, 4: number of independent 1-bit serial channels (≥1).
- WINDOW, 8: window depth in samples (≥2).
- CNT_W, localparam = $clog2(WINDOW+1): width of each per-channel count.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- clear  in  1  synchronous flush of all window state; priority over in_valid.
- in_valid  in  1  qualifies in_data; a sample is accepted on every clk edge where in_valid=1 and clear=0.
- in_data  in  CHANNELS  one new bit per channel; bit c belongs to channel c.
- threshold  in  CNT_W  comparison threshold, sampled on each accepted sample.
- mode  in  2  comparison: 00 count ≥ threshold, 01 count == threshold, 10 count ≤ threshold, 11 count > threshold.
- out_valid  out  1  one-cycle pulse: hit/count were updated by the last accepted sample.
- hit  out  CHANNELS  per-channel comparison result, registered.
- count  out  CHANNELS*CNT_W  per-channel ones count; channel c at bits [c*CNT_W +: CNT_W].
- primed  out  1  1 once WINDOW samples have been accepted since the last reset or clear.

## Operation
- Per channel: WINDOW-bit shift register (newest at bit 0) and a running CNT_W-bit count.
- On an accepted sample:
  - shift_c ← {shift_c[WINDOW-2:0], in_data[c]}.
  - count_c ← count_c + in_data[c] − shift_c[WINDOW-1].
  - The count is never recomputed by popcount. Its invariant is count_c == popcount(shift_c) at all times.
  - hit[c] is evaluated on the new count against the threshold and mode present on that edge.
- The count is bounded to 0..WINDOW. The add and subtract must be done at CNT_W+1 bits or ordered so no intermediate wrap occurs.
- No accepted sample: shift registers, counts, hit, and primed hold. out_valid=0.
- Fill counter: increments per accepted sample and saturates at WINDOW. primed = (fill == WINDOW).
- Unfilled window slots count as 0. hit is produced before primed; consumers gate with primed if required.
- threshold > WINDOW is legal:
  - mode 00, 01, 11: hit=0.
  - mode 10: hit=1.
- clear=1: shift registers, counts, fill, hit, out_valid, and primed go to 0 on that edge. Any in_valid in the same cycle is dropped.
- Channels are fully independent. They share only in_valid, threshold, mode, and clear.

## Timing
- Reset values: hit=0, count=0, out_valid=0, primed=0. All shift registers and the fill counter are 0.
- Reset mid-stream discards the window immediately (asynchronous). The first accepted sample after deassertion is treated as sample 1.
- Latency: the sample accepted at edge N is reflected in count, hit, and out_valid after edge N. out_valid is high during cycle N+1.
- Back-to-back in_valid gives one update per cycle, with out_valid held high continuously.
- primed rises after the WINDOW-th accepted sample's edge and stays high until reset or clear.
- threshold and mode changes have no effect until the next accepted sample.
- No combinational path from inputs to outputs.

## Test plan
- **Default-equivalent check.** CHANNELS=1, WINDOW=3, threshold=2, mode=00. Stream 1,0,1,0,0,1,1 with in_valid every cycle.
  - Required hit: 0,0,1,0,0,0,1.
  - Required count: 1,1,2,1,1,1,2.
  - primed rises after the 3rd sample.
- **Gapped valid.** WINDOW=8, channel 0 all-ones with in_valid every other cycle.
  - count steps 1..8, then holds at 8.
  - out_valid pulses only after accepted samples.
  - primed rises after the 8th accepted sample, not the 8th cycle.
- **Modes and out-of-range threshold.** WINDOW=8, count=5.
  - threshold=5: mode 00→1, 01→1, 10→1, 11→0.
  - threshold=9: mode 00→0, 10→1.
- **Clear priority.** Fill 8 ones, then assert clear and in_valid=1 together.
  - Next cycle: count=0, hit=0, primed=0, out_valid=0.
  - Next accepted sample gives count=1.
- **Async reset mid-operation.** Pulse reset between clock edges while count=6.
  - All outputs are 0 before the next edge.
- **Multi-channel independence.** CHANNELS=4, in_data=4'b0101 for 8 samples, threshold=8, mode=00.
  - Required hit=4'b0101.
  - Required counts, channels 3..0: 0,8,0,8.
  - Random streams: each count equals a reference popcount of that channel's window every cycle.
